// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - segment constants and display record for the BCD scan driver
package disp_pkg;

    localparam int IDX_W = 2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    // Active-low {g,f,e,d,c,b,a}, indexed by digit value 0..9
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    typedef struct packed {
        logic [11:0] bcd;
        logic        neg;
        logic        err;
    } disp_rec_t;

    localparam disp_rec_t DISP_RESET = '{bcd: 12'h000, neg: 1'b0, err: 1'b0};

endpackage

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - BCD nibble to active-low seven-segment pattern
module seg7_encode
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg = (nibble > 4'd9) ? SEG_E : SEG_DIGIT[nibble];
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - 4-digit multiplexed seven-segment driver with frame-aligned commit
module bcd_display_scan
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        neg_in,
    input  logic        err_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0]    pcnt;
    logic [IDX_W-1:0] idx;
    disp_rec_t        pend;
    disp_rec_t        disp;
    logic             pending_valid;

    logic             slot_tick;
    logic             frame;
    logic             transfer;
    logic [3:0]       nibble;
    logic             nib_blank;
    logic [6:0]       enc_seg;
    logic [6:0]       seg_next;
    logic [3:0]       an_next;

    assign in_ready  = !pending_valid;
    assign transfer  = in_valid && in_ready;
    assign slot_tick = (pcnt == PCNT_LAST);
    assign frame     = slot_tick && (idx == IDX_W'(3));
    assign dp        = 1'b1;

    // Leading-zero blanking: tens hides only when hundreds is also zero
    always_comb begin
        nibble    = 4'd0;
        nib_blank = 1'b1;
        case (idx)
            2'd0: begin
                nibble    = disp.bcd[3:0];
                nib_blank = 1'b0;
            end
            2'd1: begin
                nibble    = disp.bcd[7:4];
                nib_blank = (disp.bcd[11:8] == 4'd0) && (disp.bcd[7:4] == 4'd0);
            end
            2'd2: begin
                nibble    = disp.bcd[11:8];
                nib_blank = (disp.bcd[11:8] == 4'd0);
            end
            default: begin
                nibble    = 4'd0;
                nib_blank = 1'b1;
            end
        endcase
    end

    seg7_encode u_encode (
        .nibble (nibble),
        .blank  (nib_blank),
        .seg    (enc_seg)
    );

    always_comb begin
        seg_next = enc_seg;
        if (disp.err) begin
            case (idx)
                2'd3:       seg_next = SEG_E;
                2'd2, 2'd1: seg_next = SEG_R;
                default:    seg_next = SEG_BLANK;
            endcase
        end else if (idx == IDX_W'(3)) begin
            seg_next = disp.neg ? SEG_MINUS : SEG_BLANK;
        end
        an_next = ~(4'b0001 << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt          <= '0;
            idx           <= '0;
            pend          <= DISP_RESET;
            disp          <= DISP_RESET;
            pending_valid <= 1'b0;
            an            <= 4'b1111;
            seg           <= SEG_BLANK;
            frame_tick    <= 1'b0;
        end else begin
            pcnt       <= slot_tick ? '0 : pcnt + PW'(1);
            idx        <= slot_tick ? idx + IDX_W'(1) : idx;
            frame_tick <= frame;
            an         <= an_next;
            seg        <= seg_next;
            // Transfer and commit are mutually exclusive since in_ready = !pending_valid
            if (frame && pending_valid) begin
                disp          <= pend;
                pending_valid <= 1'b0;
            end else if (transfer) begin
                pend          <= '{bcd: bcd_in, neg: neg_in, err: err_in};
                pending_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb/tb_bcd_display_scan.sv - scoreboard bench for bcd_display_scan with a 16-cycle frame
module tb_bcd_display_scan;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000;
    localparam logic [6:0] BL = 7'b1111111, MI = 7'b0111111, SE = 7'b0000110, SR = 7'b0101111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] bcd_in = 12'h000;
    logic        neg_in = 1'b0;
    logic        err_in = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    logic [27:0] exp_q[$];
    logic [6:0]  cap_seg[4];
    logic [3:0]  cap_an[4];

    bcd_display_scan #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .neg_in     (neg_in),
        .err_in     (err_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [11:0] b, input logic n, input logic e, input logic [27:0] exp_frame);
        bit ok = 0;
        bcd_in = b; neg_in = n; err_in = e; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1 within 100 cycles", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            exp_q.push_back(exp_frame);
        end
    endtask

    // Waits for the frame_tick cycle on which in_ready is high (commit done)
    task automatic wait_commit(output bit ok, output bit early);
        ok = 0; early = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame_tick && in_ready) begin ok = 1; break; end
            if (!frame_tick && in_ready) early = 1;
        end
    endtask

    task automatic capture_slots();
        for (int k = 0; k < 4; k++) begin
            repeat (k == 0 ? 1 : 4) @(negedge clk);
            cap_seg[k] = seg;
            cap_an[k]  = an;
        end
    endtask

    task automatic test_reset();
        logic [3:0] ea;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b required 1111", an); end
        checks++; if (seg !== BL) begin errors++; $display("FAIL reset_seg: got %b required %b", seg, BL); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b required 1", dp); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b required 0", frame_tick); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", in_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (an !== 4'b1111 || seg !== BL) begin errors++; $display("FAIL release_hold: an=%b seg=%b required 1111 %b", an, seg, BL); end
        @(negedge clk);
        checks++; if (an !== 4'b1110 || seg !== S0) begin errors++; $display("FAIL release_slot0: an=%b seg=%b required 1110 %b", an, seg, S0); end
        for (int k = 1; k < 4; k++) begin
            repeat (4) @(negedge clk);
            ea = 4'b1111; ea[k] = 1'b0;
            checks++;
            if (an !== ea || seg !== BL) begin
                errors++;
                $display("FAIL reset_slot%0d: an=%b seg=%b required %b %b", k, an, seg, ea, BL);
            end
        end
    endtask

    task automatic compare_popped_frame_test_commit();
    endtask

    task automatic test_commit();
        bit ok, early;
        logic [27:0] ef;
        logic [3:0] ea;
        send(12'h042, 1'b0, 1'b0, {BL, BL, S4, S2});
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL commit_ready_low: got %b required 0", in_ready); end
        wait_commit(ok, early);
        checks++; if (!ok) begin errors++; $display("FAIL commit_timeout: no commit within 64 cycles, required one"); end
        checks++; if (early) begin errors++; $display("FAIL commit_ready_early: in_ready rose before frame_tick, required low"); end
        capture_slots();
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL commit_queue: size 0 required 1");
        end else begin
            ef = exp_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                ea = 4'b1111; ea[k] = 1'b0;
                if (cap_seg[k] !== ef[k*7 +: 7] || cap_an[k] !== ea) begin
                    errors++;
                    $display("FAIL commit_slot%0d: an=%b seg=%b required %b %b", k, cap_an[k], cap_seg[k], ea, ef[k*7 +: 7]);
                end
                if (k < 3) checks++;
            end
        end
    endtask

    task automatic test_patterns();
        logic [11:0] tb_bcd[2] = '{12'h105, 12'h999};
        logic        tb_neg[2] = '{1'b1, 1'b0};
        logic        tb_err[2] = '{1'b0, 1'b1};
        logic [27:0] tb_exp[2] = '{{MI, S1, S0, S5}, {SE, SR, SR, BL}};
        bit ok, early;
        logic [27:0] ef;
        for (int t = 0; t < 2; t++) begin
            send(tb_bcd[t], tb_neg[t], tb_err[t], tb_exp[t]);
            wait_commit(ok, early);
            checks++; if (!ok) begin errors++; $display("FAIL pattern%0d_timeout: no commit, required one", t); end
            capture_slots();
            ef = (exp_q.size() != 0) ? exp_q.pop_front() : 28'h0;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (cap_seg[k] !== ef[k*7 +: 7]) begin
                    errors++;
                    $display("FAIL pattern%0d_slot%0d: seg=%b required %b", t, k, cap_seg[k], ef[k*7 +: 7]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok = 0, early;
        logic [27:0] ef;
        bcd_in = 12'h007; neg_in = 1'b0; err_in = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL b2b_a_ready: in_ready=%b required 1", in_ready); end
        @(posedge clk); #1;
        exp_q.push_back({BL, BL, BL, S7});
        bcd_in = 12'h250;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b required 0", in_ready); end
        wait_commit(ok, early);
        checks++; if (!ok || early) begin errors++; $display("FAIL b2b_a_commit: ok=%0d early=%0d required 1 0", ok, early); end
        exp_q.push_back({BL, S2, S5, S0});
        capture_slots();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_b_pending: in_ready=%b required 0", in_ready); end
        for (int f = 0; f < 2; f++) begin
            if (f == 1) begin
                wait_commit(ok, early);
                checks++; if (!ok) begin errors++; $display("FAIL b2b_b_commit: no commit, required one"); end
                capture_slots();
            end
            ef = (exp_q.size() != 0) ? exp_q.pop_front() : 28'h0;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (cap_seg[k] !== ef[k*7 +: 7]) begin
                    errors++;
                    $display("FAIL b2b_frame%0d_slot%0d: seg=%b required %b", f, k, cap_seg[k], ef[k*7 +: 7]);
                end
            end
        end
    endtask

    task automatic test_reset_discard();
        bit ok, early;
        logic [27:0] ef;
        send(12'h123, 1'b0, 1'b0, {BL, S1, S2, 7'b0110000});
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (an !== 4'b1111 || in_ready !== 1'b1) begin errors++; $display("FAIL discard_async: an=%b in_ready=%b required 1111 1", an, in_ready); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back({BL, BL, BL, S0});
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL discard_ready: got %b required 1", in_ready); end
        for (int f = 0; f < 2; f++) begin
            wait_commit(ok, early);
            checks++; if (!ok) begin errors++; $display("FAIL discard_tick%0d: no frame_tick, required one", f); end
            capture_slots();
            ef = (f == 0 && exp_q.size() != 0) ? exp_q.pop_front() : ef;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (cap_seg[k] !== ef[k*7 +: 7]) begin
                    errors++;
                    $display("FAIL discard_frame%0d_slot%0d: seg=%b required %b", f, k, cap_seg[k], ef[k*7 +: 7]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_patterns();
        test_back_to_back();
        test_reset_discard();
        compare_popped_frame_test_commit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
